// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, one partial product per cycle, start/busy/done handshake.
// Optional SEQ_MULTIPLIER_MAC_EN adds port c and initialises the accumulator with it (a*b + c).
module seq_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
`ifdef SEQ_MULTIPLIER_MAC_EN
  input  logic [2*DATA_WIDTH-1:0] c,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH:0]   product
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         sum;
  logic [PW-1:0]         acc_init;

`ifdef SEQ_MULTIPLIER_MAC_EN
  assign acc_init = PW'(c);
`else
  assign acc_init = '0;
`endif

  // Accumulator value after this cycle's iteration; also the product on the last one.
  always_comb begin
    sum = acc;
    if (b_sh[0]) begin
      sum = acc + a_sh;
    end
  end

  assign busy = (state == S_MULT) || (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= PW'(a);
            b_sh  <= b;
            acc   <= acc_init;
            cnt   <= CW'(DATA_WIDTH);
            state <= S_MULT;
          end
        end
        S_MULT: begin
          acc  <= sum;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            product <= sum;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier against an arithmetic reference model.
// Build with SEQ_MULTIPLIER_MAC_EN defined to exercise the multiply-accumulate variant.
module tb_seq_multiplier;

  localparam int DW = 8;
  localparam int PW = 2 * DW + 1;
`ifdef SEQ_MULTIPLIER_MAC_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
`ifdef SEQ_MULTIPLIER_MAC_EN
  logic [2*DW-1:0] c;
`endif
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  seq_multiplier #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef SEQ_MULTIPLIER_MAC_EN
    .c       (c),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    longint p;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  int     cyc;
  int     next_free;
  int     last_start;
  longint held;
  int     checks;
  int     errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an accepted start in cycle k completes in cycle k+DW+1 with a*b(+c);
  // the block is free again from cycle k+DW+2. Starts any earlier are ignored.
  task automatic drive(input logic st, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [2*DW-1:0] cv);
    exp_t e;
    @(negedge clk);
    start = st;
    a     = av;
    b     = bv;
`ifdef SEQ_MULTIPLIER_MAC_EN
    c     = cv;
`endif
    if (st && cyc >= next_free) begin
      e.p   = longint'(av) * longint'(bv) + (MAC ? longint'(cv) : 64'd0);
      e.cyc = cyc + DW + 1;
      q.push_back(e);
      last_start = cyc;
      next_free  = cyc + DW + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, DW'($urandom), DW'($urandom), (2*DW)'($urandom));
    end
  endtask

  task automatic pulse(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [2*DW-1:0] cv);
    drive(1'b1, av, bv, cv);
  endtask

  // Monitor: pops the scoreboard whenever done is seen, otherwise checks product is held.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", longint'(busy), longint'((cyc > last_start) && (cyc <= last_start + DW + 1)));
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("product", longint'(product), e.p);
          chk("done_cycle", longint'(cyc), longint'(e.cyc));
          held = e.p;
        end
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("missing_done", 0, 1);
          held = e.p;
        end
        chk("product_held", longint'(product), held);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    next_free  = 0;
    last_start = -100;
    held       = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    a          = '0;
    b          = '0;
`ifdef SEQ_MULTIPLIER_MAC_EN
    c          = '0;
`endif
    #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_product", longint'(product), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    pulse(8'd13, 8'd11, 16'd0);
    idle(DW + 7);
    pulse(8'd255, 8'd255, 16'd0);
    idle(DW + 3);
    pulse(8'd0, 8'd200, 16'd0);
    idle(DW + 2);
    pulse(8'd200, 8'd0, 16'd0);
    idle(DW + 2);

    // Start during MULT must be ignored and must not resample operands.
    pulse(8'd6, 8'd7, 16'd0);
    idle(2);
    pulse(8'd100, 8'd100, 16'd0);
    idle(DW + 4);

    // Asynchronous reset in the middle of an operation.
    pulse(8'd50, 8'd50, 16'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_product", longint'(product), 0);
    q.delete();
    held       = 0;
    last_start = -100;
    next_free  = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(DW + 4);
    pulse(8'd3, 8'd4, 16'd0);
    idle(DW + 3);

`ifdef SEQ_MULTIPLIER_MAC_EN
    pulse(8'd255, 8'd255, 16'hFFFF);
    idle(DW + 3);
`endif

    // start held high: back-to-back operations every DW+2 cycles.
    for (int i = 0; i < 4 * (DW + 2); i++) begin
      drive(1'b1, DW'($urandom), DW'($urandom), (2*DW)'($urandom));
    end
    idle(DW + 3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b1, 8'd255, 8'd255, 16'hFFFF);
      end else begin
        drive($urandom_range(0, 3) == 0, DW'($urandom), DW'($urandom), (2*DW)'($urandom));
      end
    end
    idle(DW + 4);
    chk("queue_drained", longint'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential shift-add multiplier; produces the (2*DATA_WIDTH+1)-bit operand consumed by the modulo reduction unit.
- Together with the reducer it forms the modular-multiply datapath: this block is the writer side and produces the `a` input; the reducer is the reader side.
- One partial product per cycle, fixed latency, start/busy/done handshake.

Parameters:
DATA_WIDTH, 8, width of each multiplicand; product port is 2*DATA_WIDTH+1 bits, matching the reducer input.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  DATA_WIDTH  multiplicand, sampled on accepted start
b  input  DATA_WIDTH  multiplier, sampled on accepted start
busy  output  1  high in MULT and DONE states
done  output  1  one-cycle pulse; product valid
product  output  2*DATA_WIDTH+1  result register, held until next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0; done=0; product=0; internal acc, a_sh, b_sh and cnt all cleared.
  - Reset mid-operation aborts the operation immediately; no done pulse is produced for the aborted operation.
- States:
  - IDLE: if start=1 at the clock edge, the following happen and the state goes to MULT:
    - a_sh <= zero-extend(a) to 2*DATA_WIDTH+1 bits
    - b_sh <= b
    - acc <= 0
    - cnt <= DATA_WIDTH
  - MULT: every edge performs one iteration:
    - if b_sh[0]=1, acc <= acc + a_sh
    - a_sh <= a_sh<<1
    - b_sh <= b_sh>>1
    - cnt <= cnt-1
    - when cnt=1, the final iteration executes; product <= the final acc value, including that iteration's add; the state goes to DONE.
  - DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- Arithmetic:
  - All adds are performed at 2*DATA_WIDTH+1 bits, unsigned; overflow is impossible.
  - product[2*DATA_WIDTH] is 0 unless MAC_EN is defined.
- Latency: start accepted at edge 0 → MULT edges 1..DATA_WIDTH → done high during the cycle after edge DATA_WIDTH. This is DATA_WIDTH+1 cycles start-to-done, independent of operand values; there is no early exit on b=0.
- busy: combinational decode, high iff state is MULT or DONE.
- start while busy (MULT or DONE) is ignored, and the operands are not resampled. start held high continuously restarts on the first IDLE cycle, giving back-to-back operations every DATA_WIDTH+2 cycles.
- Changing a/b after acceptance has no effect.
- product changes only on the edge entering DONE and on reset.
- done and product are registered, and connect directly to the reducer's start and a inputs.

Optional Feature:
- Macro: SEQ_MULTIPLIER_MAC_EN
- Defined:
  - Adds input port c, 2*DATA_WIDTH bits.
  - On accepted start, acc <= zero-extend(c) instead of 0, so product = a*b + c.
  - The maximum value (2^W-1)^2 + 2^(2W)-1 uses bit 2*DATA_WIDTH.
  - Latency is unchanged.
- Undefined: port c is absent, acc initializes to 0, and product[2*DATA_WIDTH] is constant 0.

Test Plan:
- W=8, rst_n released, a=13, b=11, start pulse 1 cycle → busy high next cycle; done high exactly 9 cycles after the start edge; product=143; product still 143 five cycles later.
- a=255, b=255 → product=65025 (0x0FE01); bit 16=0; done is a single-cycle pulse.
- a=0, b=200 and then a=200, b=0 → product=0 both times; latency still 9 cycles.
- a=6, b=7 started; at cycle 3 apply start with a=100, b=100 → ignored; product=42 after 9 cycles; no second done.
- a=50, b=50 started; rst_n low at cycle 4 → busy=0, done=0, product=0 asynchronously; after release, no done appears until a new start; a new start with a=3, b=4 gives product=12.
- SEQ_MULTIPLIER_MAC_EN defined, a=255, b=255, c=65535 → product=130560 (0x1FE00, bit 16=1). Undefined build with start held high → done pulses every 10 cycles.
